// File: rtl/mod_enc_shift_ctrl.sv
// Sequencer that streams one AES state row by row through the 4-byte ShiftRows shifter.
// Optional MOD_ENC_SHIFT_CTRL_CHK_EN adds a sticky err output for shifter handshake faults.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  ST_IDLE  | waiting for in_valid; in_ready high
//  ST_ISSUE | rows 0..3 driven to shifter; previous row captured
//  ST_DRAIN | last shifted row (row 3) captured
//  ST_OUT   | out_valid high, out_state held until out_ready
module mod_enc_shift_ctrl #(
   parameter int NB   = 16,
   parameter int NROW = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*NB-1:0]     in_state,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [8*NB-1:0]     out_state,
   output logic                busy,
   output logic                sh_resetn,
   output logic                sh_wr_en,
   output logic [8*NROW-1:0]   sh_inp,
   input  logic [8*NROW-1:0]   sh_outp,
   input  logic                sh_done
`ifdef MOD_ENC_SHIFT_CTRL_CHK_EN
   ,
   output logic                err
`endif
);

   localparam int SW = 8 * NB;
   localparam int RW = 8 * NROW;

   if (NB != 16 || NROW != 4) begin : g_bad_param
      $error("mod_enc_shift_ctrl supports only NB=16, NROW=4");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

   state_t          r_state;
   logic [1:0]      r_row;
   logic [SW-1:0]   r_in;
   logic [SW-1:0]   r_out;
   logic            r_out_valid;
   logic            r_sh_wr_en;
   logic [RW-1:0]   r_sh_inp;

   // Row r of a column-major state: byte c of the row is state byte 4c+r.
   function automatic logic [RW-1:0] get_row(input logic [SW-1:0] s, input logic [1:0] r);
      logic [RW-1:0] row;
      row = '0;
      for (int c = 0; c < NROW; c++) begin
         row[8*c +: 8] = s[8*(NROW*c + int'(r)) +: 8];
      end
      return row;
   endfunction

   function automatic logic [SW-1:0] put_row(input logic [SW-1:0] s, input logic [RW-1:0] row,
                                             input logic [1:0] r);
      logic [SW-1:0] res;
      res = s;
      for (int c = 0; c < NROW; c++) begin
         res[8*(NROW*c + int'(r)) +: 8] = row[8*c +: 8];
      end
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (resetn) begin
         r_state     <= ST_IDLE;
         r_row       <= 2'd0;
         r_in        <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_sh_wr_en  <= 1'b1;
         r_sh_inp    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_in       <= in_state;
                  r_row      <= 2'd0;
                  r_sh_wr_en <= 1'b0;
                  r_sh_inp   <= get_row(in_state, 2'd0);
                  r_state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // shifter output lags the issued row by one cycle
               if (r_row != 2'd0 && sh_done) begin
                  r_out <= put_row(r_out, sh_outp, r_row - 2'd1);
               end
               if (r_row == 2'd3) begin
                  r_row      <= 2'd0;
                  r_sh_wr_en <= 1'b1;
                  r_sh_inp   <= '0;
                  r_state    <= ST_DRAIN;
               end else begin
                  r_row    <= r_row + 2'd1;
                  r_sh_inp <= get_row(r_in, r_row + 2'd1);
               end
            end
            ST_DRAIN: begin
               if (sh_done) begin
                  r_out <= put_row(r_out, sh_outp, 2'd3);
               end
               r_out_valid <= 1'b1;
               r_state     <= ST_OUT;
            end
            ST_OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef MOD_ENC_SHIFT_CTRL_CHK_EN
   logic r_err;
   logic w_cap_cycle;
   logic w_quiet_cycle;

   assign w_cap_cycle   = (r_state == ST_ISSUE && r_row != 2'd0) || (r_state == ST_DRAIN);
   assign w_quiet_cycle = (r_state == ST_IDLE) || (r_state == ST_OUT);

   always_ff @(posedge clk) begin
      if (resetn) begin
         r_err <= 1'b0;
      end else if ((w_cap_cycle && !sh_done) || (w_quiet_cycle && sh_done)) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`endif

   assign in_ready  = (r_state == ST_IDLE) && !resetn;
   assign busy      = (r_state != ST_IDLE);
   assign sh_resetn = ~resetn;
   assign sh_wr_en  = r_sh_wr_en;
   assign sh_inp    = r_sh_inp;
   assign out_valid = r_out_valid;
   assign out_state = r_out;

endmodule

// File: tb/tb_mod_enc_shift_ctrl.sv
// Directed bench for mod_enc_shift_ctrl with a behavioural ShiftRows shifter model.
// Define MOD_ENC_SHIFT_CTRL_CHK_EN to also exercise the err output.
module tb_mod_enc_shift_ctrl;

   logic          clk = 1'b0;
   logic          resetn;
   logic          in_valid;
   logic          in_ready;
   logic [127:0]  in_state;
   logic          out_valid;
   logic          out_ready;
   logic [127:0]  out_state;
   logic          busy;
   logic          sh_resetn;
   logic          sh_wr_en;
   logic [31:0]   sh_inp;
   logic [31:0]   sh_outp;
   logic          sh_done;
`ifdef MOD_ENC_SHIFT_CTRL_CHK_EN
   logic          err;
`endif

   mod_enc_shift_ctrl dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy),
      .sh_resetn (sh_resetn),
      .sh_wr_en  (sh_wr_en),
      .sh_inp    (sh_inp),
      .sh_outp   (sh_outp),
      .sh_done   (sh_done)
`ifdef MOD_ENC_SHIFT_CTRL_CHK_EN
      ,
      .err       (err)
`endif
   );

   always #5 clk = ~clk;

   // Shifter model: rotates inp left by its row counter, registered, done one cycle later.
   logic [1:0]  m_cnt;
   logic [31:0] m_outp;
   logic        m_done;
   logic        m_mask;
   logic [1:0]  rows[$];

   always @(posedge clk) begin
      if (!sh_resetn) begin
         m_cnt  <= 2'd0;
         m_outp <= '0;
         m_done <= 1'b0;
      end else if (!sh_wr_en) begin
         for (int c = 0; c < 4; c++) begin
            m_outp[8*c +: 8] <= sh_inp[8*((c + int'(m_cnt)) % 4) +: 8];
         end
         m_done <= 1'b1;
         m_cnt  <= m_cnt + 2'd1;
         rows.push_back(m_cnt);
      end else begin
         m_done <= 1'b0;
      end
   end

   assign sh_outp = m_outp;
   assign sh_done = m_done & ~m_mask;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] be2le(input logic [127:0] t);
      logic [127:0] s;
      for (int b = 0; b < 16; b++) s[8*b +: 8] = t[127-8*b -: 8];
      return s;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int b = 0; b < 16; b++) o[8*b +: 8] = s[8*(4*(((b/4) + (b%4)) % 4) + (b%4)) +: 8];
      return o;
   endfunction

   task automatic check_rows(input string tag);
      logic [7:0] seq;
      seq = 8'hff;
      if (rows.size() == 4) seq = {rows[3], rows[2], rows[1], rows[0]};
      check(tag, seq, 8'he4);
   endtask

   task automatic wait_out(input string tag);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check(tag, n, 5);
   endtask

   task automatic do_state(input logic [127:0] s, input logic [127:0] exp, input string tag);
      rows.delete();
      in_state = s;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_out({tag, "_lat"});
      check({tag, "_out"}, out_state, exp);
      check_rows({tag, "_rows"});
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   localparam logic [127:0] T1_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] T1_EXP = 128'h0b06010c07020d08030e09040f0a0500;
   localparam logic [127:0] F_IN   = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] F_EXP  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

   initial begin
      logic [127:0] vals[3];
      int           t_acc[3];
      int           n;

      resetn    = 1'b1;
      in_valid  = 1'b0;
      in_state  = '0;
      out_ready = 1'b0;
      m_mask    = 1'b0;
      tick();
      tick();
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_state", out_state, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_sh_wr_en", sh_wr_en, 1'b1);
      check("rst_sh_inp", sh_inp, '0);
      check("rst_sh_resetn", sh_resetn, 1'b0);
      resetn = 1'b0;
      tick();
      check("idle_in_ready", in_ready, 1'b1);
      check("idle_sh_resetn", sh_resetn, 1'b1);

      // Test 1: byte b = b, with a look at the first issued row
      rows.delete();
      in_state = T1_IN;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t1_busy", busy, 1'b1);
      check("t1_in_ready", in_ready, 1'b0);
      check("t1_sh_wr_en", sh_wr_en, 1'b0);
      check("t1_sh_inp_row0", sh_inp, 32'h0c080400);
      wait_out("t1_lat");
      check("t1_out", out_state, T1_EXP);
      check_rows("t1_rows");
      release_out();
      check("t1_done_valid", out_valid, 1'b0);
      check("t1_done_ready", in_ready, 1'b1);

      // Test 2: FIPS-197 round 1 ShiftRows
      do_state(be2le(F_IN), be2le(F_EXP), "t2");
      release_out();

      // Test 3: output stall with a competing in_valid
      do_state(T1_IN, T1_EXP, "t3");
      in_state = be2le(F_IN);
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t3_hold_valid", out_valid, 1'b1);
         check("t3_hold_state", out_state, T1_EXP);
         check("t3_hold_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t3_rel_valid", out_valid, 1'b0);
      check("t3_rel_ready", in_ready, 1'b1);
      rows.delete();
      tick();
      in_valid = 1'b0;
      wait_out("t3b_lat");
      check("t3b_out", out_state, be2le(F_EXP));
      check_rows("t3b_rows");
      release_out();

      // Test 4: back-to-back with downstream always ready
      vals[0] = T1_IN;
      vals[1] = be2le(F_IN);
      vals[2] = 128'h3243f6a8885a308d313198a2e0370734;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_state = vals[k];
         n = 0;
         while (!in_ready && n < 20) begin
            tick();
            n++;
         end
         t_acc[k] = cyc;
         rows.delete();
         tick();
         wait_out("t4_lat");
         check("t4_out", out_state, shift_rows(vals[k]));
         check_rows("t4_rows");
         if (k > 0) check("t4_period", t_acc[k] - t_acc[k-1], 7);
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      check("t4_end_idle", busy, 1'b0);

      // Test 5: reset on the 3rd ISSUE cycle
      rows.delete();
      in_state = be2le(F_IN);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("t5_issuing", sh_wr_en, 1'b0);
      resetn = 1'b1;
      tick();
      check("t5_busy", busy, 1'b0);
      check("t5_out_valid", out_valid, 1'b0);
      check("t5_sh_resetn", sh_resetn, 1'b0);
      check("t5_in_ready", in_ready, 1'b0);
      resetn = 1'b0;
      tick();
      check("t5_idle_ready", in_ready, 1'b1);
      do_state(T1_IN, T1_EXP, "t5");
      release_out();

`ifdef MOD_ENC_SHIFT_CTRL_CHK_EN
      // Test 6: missing done during DRAIN sets a sticky err
      check("t6_err_clean", err, 1'b0);
      in_state = T1_IN;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      m_mask = 1'b1;
      tick();
      m_mask = 1'b0;
      check("t6_out_valid", out_valid, 1'b1);
      check("t6_err_set", err, 1'b1);
      release_out();
      tick();
      tick();
      check("t6_err_sticky", err, 1'b1);
      resetn = 1'b1;
      tick();
      check("t6_err_cleared", err, 1'b0);
      resetn = 1'b0;
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
